// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared definitions for the countdown timer: state encoding
//               and the default count width.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

  // Default bit width of the load value and count output
  localparam int C_DEFAULT_WIDTH = 4;

  // Controller states; encodings are fixed so other blocks can decode them
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : timer_pkg
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer
// Description : Loadable down-counter. A start value is taken over a
//               valid/ready handshake, decremented on enabled edges, and
//               terminal count is flagged by a one-cycle done pulse.
//               Optional macro COUNTDOWN_AUTO_RELOAD_EN selects periodic
//               mode: on terminal count the start value is reloaded and the
//               timer keeps running until aborted.
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = C_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] C_ZERO = '0;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  // Start value kept for periodic reload, and the in-RUN terminal-count flag
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] w_reload_next;
  logic             r_pulse;
  logic             w_pulse_next;
`endif

  // State, count and (optional) reload registers; clr overrides everything
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state  <= ST_IDLE;
      r_q      <= C_ZERO;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      r_reload <= C_ZERO;
      r_pulse  <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_q      <= w_q_next;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      r_reload <= w_reload_next;
      r_pulse  <= w_pulse_next;
`endif
    end
  end

  // Next-state and next-count logic; hold everything unless a case says otherwise
  always_comb begin
    w_state_next  = r_state;
    w_q_next      = r_q;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    w_reload_next = r_reload;
    w_pulse_next  = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        // enable and abort have no effect until a value is loaded
        if (load_valid) begin
          w_q_next = load_val;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          w_reload_next = load_val;
`endif
          // A zero load skips counting and goes straight to the done pulse
          w_state_next = (load_val != C_ZERO) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          // Cancel wins over a simultaneous enable; count is frozen
          w_state_next = ST_IDLE;
        end else if (enable) begin
          if (r_q > C_ONE) begin
            w_q_next = r_q - C_ONE;
          end else begin
            // r_q is 1 here: a zero value never reaches RUN, so no wrap
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            w_q_next     = r_reload;
            w_pulse_next = 1'b1;
`else
            w_q_next     = C_ZERO;
            w_state_next = ST_DONE;
`endif
          end
        end
      end
      ST_DONE: begin
        // Single pulse cycle; load_valid and abort are ignored here
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Handshake and status outputs decoded from the registered state
  assign load_ready = (r_state == ST_IDLE);
  assign busy       = (r_state == ST_RUN);
  assign q          = r_q;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  assign done       = (r_state == ST_DONE) || r_pulse;
`else
  assign done       = (r_state == ST_DONE);
`endif

endmodule : countdown_timer
`default_nettype wire
